// File: rtl/pulse_handshake_rx.sv
// Receive side of a four-phase req/ack pulse handshake. It synchronizes req_in,
// regenerates a PULSE_LEN-cycle pulse, returns a level ack and tracks errors.
module pulse_handshake_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             err_clr,
    output logic             ack_out,
    output logic             pulse_out,
    output logic             pulse_flag,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             proto_err,
    output logic             timeout_err
);

    localparam int                WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0]        LEN_M1   = 8'(PULSE_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                req_s;
    logic [7:0]          len_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    // Plain flop chain; only its last stage is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack_out     <= 1'b0;
            pulse_out   <= 1'b0;
            pulse_flag  <= 1'b0;
            pulse_cnt   <= '0;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
            len_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            // Clear first so that any set below in the same cycle takes priority.
            if (err_clr) begin
                proto_err   <= 1'b0;
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_s) begin
                        state      <= PULSE;
                        pulse_out  <= 1'b1;
                        ack_out    <= 1'b1;
                        pulse_flag <= 1'b1;
                        pulse_cnt  <= pulse_cnt + CNT_W'(1);
                        len_cnt    <= LEN_M1;
                    end
                end
                PULSE: begin
                    if (!req_s) proto_err <= 1'b1;
                    if (len_cnt == 8'd0) begin
                        pulse_out <= 1'b0;
                        if (req_s) begin
                            state    <= WAIT_LOW;
                            wait_cnt <= '0;
                        end else begin
                            state      <= IDLE;
                            ack_out    <= 1'b0;
                            pulse_flag <= 1'b0;
                        end
                    end else begin
                        len_cnt <= len_cnt - 8'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!req_s) begin
                        state      <= IDLE;
                        ack_out    <= 1'b0;
                        pulse_flag <= 1'b0;
                    end else begin
                        // Saturate so a cleared timeout is not re-raised by wrap-around.
                        if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (TIMEOUT != 0 && wait_cnt == WAIT_LIM - WAIT_W'(1))
                            timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ack_out    <= 1'b0;
                    pulse_out  <= 1'b0;
                    pulse_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_handshake_rx.sv
// Directed bench: a per-cycle vector table on a default instance, then
// hand-written multi-cycle sequences on a long-pulse / short-timeout instance.
module tb_pulse_handshake_rx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic       rst_a = 1'b1, req_a = 1'b0, clr_a = 1'b0;
    logic       ack_a, pulse_a, flag_a, perr_a, terr_a;
    logic [7:0] cnt_a;

    // Instance B: PULSE_LEN=4, CNT_W=4, TIMEOUT=10
    logic       rst_b = 1'b1, req_b = 1'b0, clr_b = 1'b0;
    logic       ack_b, pulse_b, flag_b, perr_b, terr_b;
    logic [3:0] cnt_b;

    pulse_handshake_rx u_a (
        .clk(clk), .rst(rst_a), .req_in(req_a), .err_clr(clr_a),
        .ack_out(ack_a), .pulse_out(pulse_a), .pulse_flag(flag_a),
        .pulse_cnt(cnt_a), .proto_err(perr_a), .timeout_err(terr_a)
    );

    pulse_handshake_rx #(.SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(4), .TIMEOUT(10)) u_b (
        .clk(clk), .rst(rst_b), .req_in(req_b), .err_clr(clr_b),
        .ack_out(ack_b), .pulse_out(pulse_b), .pulse_flag(flag_b),
        .pulse_cnt(cnt_b), .proto_err(perr_b), .timeout_err(terr_b)
    );

    typedef struct {
        logic       rst, req, clr;
        logic       ack, pulse, flag;
        logic [7:0] cnt;
        logic       perr, terr;
    } vec_t;

    vec_t tbl [15];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rises_b = 0;
    logic prev_pulse_b = 1'b0;

    function automatic vec_t mk(input logic rst, req, clr, ack, pulse, flag,
                                input int cnt, input logic perr, terr);
        vec_t v;
        v.rst = rst; v.req = req; v.clr = clr;
        v.ack = ack; v.pulse = pulse; v.flag = flag;
        v.cnt = 8'(cnt); v.perr = perr; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later; tracks B pulse rises.
    task automatic tick;
        @(posedge clk);
        #1;
        if (pulse_b && !prev_pulse_b) rises_b++;
        prev_pulse_b = pulse_b;
    endtask

    // One full protocol-correct handshake on B: hold req until ack is seen
    // and the pulse is over, then drop it and wait for ack to fall.
    task automatic handshake_b;
        int n;
        req_b = 1'b1;
        n = 0;
        while (!(ack_b && !pulse_b) && n < 30) begin tick(); n++; end
        chk("hs_ack_rise", int'(ack_b && !pulse_b), 1);
        req_b = 1'b0;
        n = 0;
        while (ack_b && n < 30) begin tick(); n++; end
        chk("hs_ack_fall", int'(ack_b), 0);
    endtask

    initial begin
        int n;
        //           rst req clr | ack pul flg cnt perr terr
        tbl[0]  = mk(1, 0, 0,      0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0,      0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0,      0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0,      1, 1, 1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 0,      1, 0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0,      1, 0, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0,      1, 0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0,      0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0,      0, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 1, 0,      0, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 0,      0, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 0,      1, 1, 1, 2, 0, 0);
        tbl[12] = mk(0, 0, 1,      0, 0, 0, 2, 1, 0);
        tbl[13] = mk(0, 0, 1,      0, 0, 0, 2, 0, 0);
        tbl[14] = mk(0, 0, 0,      0, 0, 0, 2, 0, 0);

        #2;
        for (int i = 0; i < 15; i++) begin
            rst_a = tbl[i].rst; req_a = tbl[i].req; clr_a = tbl[i].clr;
            tick();
            chk($sformatf("a_ack[%0d]", i),   int'(ack_a),   int'(tbl[i].ack));
            chk($sformatf("a_pulse[%0d]", i), int'(pulse_a), int'(tbl[i].pulse));
            chk($sformatf("a_flag[%0d]", i),  int'(flag_a),  int'(tbl[i].flag));
            chk($sformatf("a_cnt[%0d]", i),   int'(cnt_a),   int'(tbl[i].cnt));
            chk($sformatf("a_perr[%0d]", i),  int'(perr_a),  int'(tbl[i].perr));
            chk($sformatf("a_terr[%0d]", i),  int'(terr_a),  int'(tbl[i].terr));
        end

        // B reset state
        chk("b_rst_ack", int'(ack_b), 0);
        chk("b_rst_pulse", int'(pulse_b), 0);
        chk("b_rst_cnt", int'(cnt_b), 0);
        chk("b_rst_terr", int'(terr_b), 0);

        // Long pulse held 50 cycles; timeout 10 edges after WAIT_LOW entry (edge k+6)
        rst_b = 1'b0; req_b = 1'b1; rises_b = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk($sformatf("b_long_pulse[%0d]", i), int'(pulse_b), int'(i >= 2 && i <= 5));
            chk($sformatf("b_long_ack[%0d]", i),   int'(ack_b),   int'(i >= 2));
            chk($sformatf("b_long_terr[%0d]", i),  int'(terr_b),  int'(i >= 16));
        end
        chk("b_long_rises", rises_b, 1);
        chk("b_long_cnt", int'(cnt_b), 1);
        req_b = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("b_drop_ack[%0d]", j),  int'(ack_b),  int'(j < 2));
            chk($sformatf("b_drop_flag[%0d]", j), int'(flag_b), int'(j < 2));
        end
        chk("b_terr_sticky", int'(terr_b), 1);
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        chk("b_terr_clr", int'(terr_b), 0);

        // Early drop: req high for a single sampled edge
        for (int i = 0; i < 9; i++) begin
            req_b = (i == 0);
            tick();
            chk($sformatf("b_early_pulse[%0d]", i), int'(pulse_b), int'(i >= 2 && i <= 5));
            chk($sformatf("b_early_ack[%0d]", i),   int'(ack_b),   int'(i >= 2 && i <= 5));
            chk($sformatf("b_early_perr[%0d]", i),  int'(perr_b),  int'(i >= 3));
        end
        chk("b_early_cnt", int'(cnt_b), 2);
        clr_b = 1'b1; tick(); clr_b = 1'b0;
        chk("b_perr_clr", int'(perr_b), 0);

        // Reset in the middle of PULSE with req still high
        req_b = 1'b1;
        n = 0;
        while (!pulse_b && n < 10) begin tick(); n++; end
        chk("b_mid_pulse_seen", int'(pulse_b), 1);
        tick();
        rst_b = 1'b1;
        tick();
        chk("b_mid_rst_pulse", int'(pulse_b), 0);
        chk("b_mid_rst_ack", int'(ack_b), 0);
        chk("b_mid_rst_flag", int'(flag_b), 0);
        chk("b_mid_rst_cnt", int'(cnt_b), 0);
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("b_restart_pulse[%0d]", i), int'(pulse_b), int'(i == 2));
            chk($sformatf("b_restart_cnt[%0d]", i),   int'(cnt_b),   int'(i == 2));
        end
        n = 0;
        while (pulse_b && n < 10) begin tick(); n++; end
        req_b = 1'b0;
        n = 0;
        while (ack_b && n < 10) begin tick(); n++; end
        chk("b_restart_ack_fall", int'(ack_b), 0);

        // 17 handshakes on a 4-bit counter
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        rises_b = 0;
        for (int h = 0; h < 17; h++) handshake_b();
        chk("b_wrap_rises", rises_b, 17);
        chk("b_wrap_cnt", int'(cnt_b), 1);
        chk("b_wrap_perr", int'(perr_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
